// File: rtl/guess_entry_pkg.sv
// Shared constants and types for the two-digit guess entry block.
// Scan codes are {extend bit, 8-bit PS/2 code}.
package guess_entry_pkg;

    localparam logic [3:0] BLANK      = 4'hF;
    localparam logic [7:0] DISP_BLANK = {BLANK, BLANK};

    localparam logic [8:0] KEY_0     = 9'h070;
    localparam logic [8:0] KEY_1     = 9'h069;
    localparam logic [8:0] KEY_2     = 9'h072;
    localparam logic [8:0] KEY_3     = 9'h07A;
    localparam logic [8:0] KEY_4     = 9'h06B;
    localparam logic [8:0] KEY_5     = 9'h073;
    localparam logic [8:0] KEY_6     = 9'h074;
    localparam logic [8:0] KEY_7     = 9'h06C;
    localparam logic [8:0] KEY_8     = 9'h075;
    localparam logic [8:0] KEY_9     = 9'h07D;
    localparam logic [8:0] KEY_ENTER = 9'h15A;
    localparam logic [8:0] KEY_ESC   = 9'h076;
    localparam logic [8:0] KEY_BKSP  = 9'h066;

    // Encoding doubles as the digit count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/guess_entry_keypad_decode.sv
// Combinational classifier for keypad scan codes.
module keypad_decode
    import guess_entry_pkg::*;
(
    input  logic [8:0] key_code,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       is_enter,
    output logic       is_esc,
    output logic       is_bksp
);

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (key_code)
            KEY_0:   digit = 4'd0;
            KEY_1:   digit = 4'd1;
            KEY_2:   digit = 4'd2;
            KEY_3:   digit = 4'd3;
            KEY_4:   digit = 4'd4;
            KEY_5:   digit = 4'd5;
            KEY_6:   digit = 4'd6;
            KEY_7:   digit = 4'd7;
            KEY_8:   digit = 4'd8;
            KEY_9:   digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    assign is_enter = (key_code == KEY_ENTER);
    assign is_esc   = (key_code == KEY_ESC);
    assign is_bksp  = (key_code == KEY_BKSP);

endmodule

// File: rtl/guess_entry.sv
// Two-digit BCD guess entry from a PS/2 keypad with typematic suppression and idle timeout.
// Optional backspace support when GUESS_ENTRY_BKSP_EN is defined.
module guess_entry
    import guess_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       key_break,
    input  logic       enable,
    output logic [7:0] guess_bcd,
    output logic       guess_valid,
    output logic [7:0] disp_bcd,
    output logic [1:0] digit_cnt,
    output logic       timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t           state, state_nxt;
    logic [7:0]       disp_nxt, guess_nxt;
    logic             guess_valid_nxt, timeout_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic             held, held_nxt;
    logic [8:0]       held_code, held_code_nxt;

    logic       is_digit, is_enter, is_esc, is_bksp;
    logic [3:0] digit;
    logic       press, repeat_press, press_ok, bksp_ok, expire;

    keypad_decode u_decode (
        .key_code (key_code),
        .is_digit (is_digit),
        .digit    (digit),
        .is_enter (is_enter),
        .is_esc   (is_esc),
        .is_bksp  (is_bksp)
    );

`ifdef GUESS_ENTRY_BKSP_EN
    assign bksp_ok = is_bksp;
`else
    logic unused_bksp;
    assign unused_bksp = is_bksp;
    assign bksp_ok     = 1'b0;
`endif

    assign press        = key_valid && !key_break;
    assign repeat_press = held && (key_code == held_code);
    assign press_ok     = press && enable && !repeat_press
                          && (is_digit || is_enter || is_esc || bksp_ok);
    // Registered pulse lands on the cycle the counter reaches TIMEOUT_CYCLES-1.
    assign expire       = (state != ST_EMPTY) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 2));
    assign digit_cnt    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            disp_bcd    <= DISP_BLANK;
            guess_bcd   <= 8'h00;
            guess_valid <= 1'b0;
            timeout     <= 1'b0;
            idle_cnt    <= '0;
            held        <= 1'b0;
            held_code   <= '0;
        end else begin
            state       <= state_nxt;
            disp_bcd    <= disp_nxt;
            guess_bcd   <= guess_nxt;
            guess_valid <= guess_valid_nxt;
            timeout     <= timeout_nxt;
            idle_cnt    <= idle_nxt;
            held        <= held_nxt;
            held_code   <= held_code_nxt;
        end
    end

    // Hold register tracks every press/release regardless of enable.
    always_comb begin
        held_nxt      = held;
        held_code_nxt = held_code;
        if (key_valid) begin
            if (!key_break) begin
                held_nxt      = 1'b1;
                held_code_nxt = key_code;
            end else if (repeat_press) begin
                held_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        disp_nxt        = disp_bcd;
        guess_nxt       = guess_bcd;
        guess_valid_nxt = 1'b0;
        timeout_nxt     = 1'b0;
        idle_nxt        = (state == ST_EMPTY) ? '0 : idle_cnt + CNT_W'(1);

        if (expire) begin
            state_nxt   = ST_EMPTY;
            disp_nxt    = DISP_BLANK;
            idle_nxt    = '0;
            timeout_nxt = 1'b1;
        end

        // An accepted press overrides a coinciding timeout.
        if (press_ok) begin
            state_nxt   = state;
            disp_nxt    = disp_bcd;
            idle_nxt    = '0;
            timeout_nxt = 1'b0;
            if (is_digit) begin
                if (state == ST_EMPTY) begin
                    disp_nxt  = {BLANK, digit};
                    state_nxt = ST_ONE;
                end else begin
                    disp_nxt  = {disp_bcd[3:0], digit};
                    state_nxt = ST_TWO;
                end
            end else if (is_enter) begin
                if (state != ST_EMPTY) begin
                    guess_nxt       = (state == ST_ONE) ? {4'h0, disp_bcd[3:0]} : disp_bcd;
                    guess_valid_nxt = 1'b1;
                    disp_nxt        = DISP_BLANK;
                    state_nxt       = ST_EMPTY;
                end
            end else if (is_esc) begin
                disp_nxt  = DISP_BLANK;
                state_nxt = ST_EMPTY;
            end else if (bksp_ok) begin
                if (state == ST_TWO) begin
                    disp_nxt  = {BLANK, disp_bcd[7:4]};
                    state_nxt = ST_ONE;
                end else if (state == ST_ONE) begin
                    disp_nxt  = DISP_BLANK;
                    state_nxt = ST_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_guess_entry.sv
// Directed self-checking bench for guess_entry (TIMEOUT_CYCLES=16).
// Covers the GUESS_ENTRY_BKSP_EN build when that macro is defined.
module tb_guess_entry;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [8:0] key_code;
    logic       key_break;
    logic       enable;
    logic [7:0] guess_bcd;
    logic       guess_valid;
    logic [7:0] disp_bcd;
    logic [1:0] digit_cnt;
    logic       timeout;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    localparam logic [8:0] K1 = 9'h069, K2 = 9'h072, K3 = 9'h07A, K4 = 9'h06B,
                           K5 = 9'h073, K6 = 9'h074, K7 = 9'h06C, K8 = 9'h075,
                           K9 = 9'h07D, ENT = 9'h15A, ESC = 9'h076, BKSP = 9'h066;

    guess_entry #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_break   (key_break),
        .enable      (enable),
        .guess_bcd   (guess_bcd),
        .guess_valid (guess_valid),
        .disp_bcd    (disp_bcd),
        .digit_cnt   (digit_cnt),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the event is sampled.
    task automatic key_event(input logic [8:0] code, input logic brk);
        key_valid = 1'b1;
        key_code  = code;
        key_break = brk;
        @(negedge clk);
        key_valid = 1'b0;
        key_break = 1'b0;
    endtask

    task automatic press(input logic [8:0] code);
        key_event(code, 1'b0);
    endtask

    task automatic release_key(input logic [8:0] code);
        key_event(code, 1'b1);
    endtask

    task automatic tap(input logic [8:0] code);
        press(code);
        release_key(code);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        rst = 1'b0; key_valid = 1'b0; key_code = '0; key_break = 1'b0; enable = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cnt", 32'(digit_cnt), 32'd0);
        check("rst_disp", 32'(disp_bcd), 32'hFF);
        check("rst_guess", 32'(guess_bcd), 32'h00);
        check("rst_gv", 32'(guess_valid), 32'd0);
        check("rst_to", 32'(timeout), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 4, 2, ENTER -> 42
        tap(K4);
        tap(K2);
        check("42_disp", 32'(disp_bcd), 32'h42);
        check("42_cnt", 32'(digit_cnt), 32'd2);
        press(ENT);
        check("42_gv", 32'(guess_valid), 32'd1);
        check("42_guess", 32'(guess_bcd), 32'h42);
        check("42_disp_clr", 32'(disp_bcd), 32'hFF);
        check("42_cnt_clr", 32'(digit_cnt), 32'd0);
        @(negedge clk);
        check("42_gv_once", 32'(guess_valid), 32'd0);
        check("42_guess_hold", 32'(guess_bcd), 32'h42);
        release_key(ENT);
        press(ENT);
        check("empty_enter_gv", 32'(guess_valid), 32'd0);
        check("empty_enter_guess", 32'(guess_bcd), 32'h42);
        release_key(ENT);

        // 7 then three held 1s -> 71
        press(K7);
        press(K1);
        press(K1);
        press(K1);
        check("rep_cnt", 32'(digit_cnt), 32'd2);
        check("rep_disp", 32'(disp_bcd), 32'h71);
        press(ENT);
        check("rep_gv", 32'(guess_valid), 32'd1);
        check("rep_guess", 32'(guess_bcd), 32'h71);
        release_key(ENT);

        // 1,2,3 -> 23; then 5 -> 05
        tap(K1);
        tap(K2);
        tap(K3);
        check("123_disp", 32'(disp_bcd), 32'h23);
        press(ENT);
        check("123_guess", 32'(guess_bcd), 32'h23);
        release_key(ENT);
        tap(K5);
        check("5_disp", 32'(disp_bcd), 32'hF5);
        check("5_cnt", 32'(digit_cnt), 32'd1);
        press(ENT);
        check("5_gv", 32'(guess_valid), 32'd1);
        check("5_guess", 32'(guess_bcd), 32'h05);
        release_key(ENT);

        // ESC clears without a guess
        tap(K8);
        tap(K9);
        press(ESC);
        check("esc_gv", 32'(guess_valid), 32'd0);
        check("esc_cnt", 32'(digit_cnt), 32'd0);
        check("esc_disp", 32'(disp_bcd), 32'hFF);
        release_key(ESC);

        // Timeout 15 cycles after the press
        press(K6);
        check("to_cnt_start", 32'(digit_cnt), 32'd1);
        saw = 1'b0;
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            if (timeout || guess_valid) saw = 1'b1;
        end
        check("to_early", 32'(saw), 32'd0);
        @(negedge clk);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_cnt", 32'(digit_cnt), 32'd0);
        check("to_disp", 32'(disp_bcd), 32'hFF);
        check("to_gv", 32'(guess_valid), 32'd0);
        @(negedge clk);
        check("to_once", 32'(timeout), 32'd0);
        release_key(K6);

        // Press on the timeout cycle wins
        press(K6);
        repeat (14) @(negedge clk);
        press(K3);
        check("race_to", 32'(timeout), 32'd0);
        check("race_cnt", 32'(digit_cnt), 32'd2);
        check("race_disp", 32'(disp_bcd), 32'h63);
        release_key(K3);
        tap(ESC);

        // Held flag still tracked while disabled
        enable = 1'b0;
        press(K9);
        check("dis_press_cnt", 32'(digit_cnt), 32'd0);
        enable = 1'b1;
        press(K9);
        check("dis_held_suppress", 32'(digit_cnt), 32'd0);
        enable = 1'b0;
        release_key(K9);
        enable = 1'b1;
        press(K9);
        check("dis_release_clears", 32'(disp_bcd), 32'hF9);
        release_key(K9);
        tap(ESC);
        tap(K4);
        enable = 1'b0;
        press(ENT);
        check("dis_enter_gv", 32'(guess_valid), 32'd0);
        check("dis_enter_cnt", 32'(digit_cnt), 32'd1);
        release_key(ENT);
        tap(K5);
        check("dis_digit_disp", 32'(disp_bcd), 32'hF4);
        enable = 1'b1;
        tap(ESC);

        // Backspace
        tap(K8);
        tap(K4);
        tap(BKSP);
`ifdef GUESS_ENTRY_BKSP_EN
        check("bksp_cnt", 32'(digit_cnt), 32'd1);
        check("bksp_disp", 32'(disp_bcd), 32'hF8);
        press(ENT);
        check("bksp_guess", 32'(guess_bcd), 32'h08);
        release_key(ENT);
        tap(K7);
        tap(BKSP);
        check("bksp_one_cnt", 32'(digit_cnt), 32'd0);
        check("bksp_one_disp", 32'(disp_bcd), 32'hFF);
`else
        check("bksp_ign_cnt", 32'(digit_cnt), 32'd2);
        check("bksp_ign_disp", 32'(disp_bcd), 32'h84);
        press(ENT);
        check("bksp_ign_guess", 32'(guess_bcd), 32'h84);
        release_key(ENT);
`endif

        // Reset mid-entry
        tap(K1);
        check("mid_cnt", 32'(digit_cnt), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(digit_cnt), 32'd0);
        check("mid_rst_disp", 32'(disp_bcd), 32'hFF);
        check("mid_rst_guess", 32'(guess_bcd), 32'h00);
        check("mid_rst_gv", 32'(guess_valid), 32'd0);
        check("mid_rst_to", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        press(ENT);
        check("post_rst_enter_gv", 32'(guess_valid), 32'd0);
        check("post_rst_enter_guess", 32'(guess_bcd), 32'h00);
        release_key(ENT);
        tap(K2);
        press(ENT);
        check("post_rst_gv", 32'(guess_valid), 32'd1);
        check("post_rst_guess", 32'(guess_bcd), 32'h02);
        release_key(ENT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
